// File: rtl/dct_acc_pkg.sv
// Shared constants and types for the cepstral DCT sequencer/accumulator.
// The coefficient and cosine register files use the same NFILT/NCEPS/SHIFT defaults.
package dct_acc_pkg;

  localparam int NFILT  = 20;
  localparam int NCEPS  = 12;
  localparam int PROD_W = 23;
  localparam int ACC_W  = 28;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 7;

  localparam int LOG_AW = $clog2(NFILT);
  localparam int COS_AW = $clog2(NFILT * NCEPS);
  localparam int IDX_W  = $clog2(NCEPS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    ACC   = 3'd3,
    OUT   = 3'd4
  } state_e;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/dct_acc_if.sv
// Handshake and data bundle between dct_acc, the DCT multiplier and the ceps consumer.
// master: environment side (start, multiplier product); slave: dct_acc.
interface dct_acc_if;
  import dct_acc_pkg::*;

  logic                     start;
  logic [LOG_AW-1:0]        log_addr;
  logic [COS_AW-1:0]        cos_addr;
  logic                     mul_en;
  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0]  ceps;
  logic [IDX_W-1:0]         ceps_idx;
  logic                     ceps_valid;
  logic                     busy;
  logic                     done;

  modport master (
    output start, prod,
    input  log_addr, cos_addr, mul_en, ceps, ceps_idx, ceps_valid, busy, done
  );

  modport slave (
    input  start, prod,
    output log_addr, cos_addr, mul_en, ceps, ceps_idx, ceps_valid, busy, done
  );

endinterface

// File: rtl/dct_acc_conv.sv
// Scales the row sum (arithmetic shift, floor) and narrows it to the output width.
// DCT_ACC_SAT_EN defined: saturate; undefined: keep the low OUT_W bits (wrap).
module dct_acc_conv #(
  parameter int ACC_W = 28,
  parameter int OUT_W = 16,
  parameter int SHIFT = 7
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] ceps
);

  logic signed [ACC_W-1:0] sh;

  assign sh = acc >>> SHIFT;

`ifdef DCT_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  always_comb begin
    if (sh > MAX_V) begin
      ceps = MAX_V[OUT_W-1:0];
    end else if (sh < MIN_V) begin
      ceps = MIN_V[OUT_W-1:0];
    end else begin
      ceps = sh[OUT_W-1:0];
    end
  end
`else
  // Upper bits are intentionally dropped in the wrapping build.
  logic unused_hi;

  assign unused_hi = ^sh[ACC_W-1:OUT_W];
  assign ceps      = sh[OUT_W-1:0];
`endif

endmodule

// File: rtl/dct_acc.sv
// Cepstral DCT sequencer: drives the 16x8 multiplier and accumulates one row per coefficient.
// Output narrowing selected by DCT_ACC_SAT_EN (see dct_acc_conv).
//
//   state | meaning
//   IDLE  | waiting for start; counters hold
//   ISSUE | mul_en high, addresses for term k stable
//   WAIT  | multiplier pipeline in flight
//   ACC   | add product into acc, advance cos_addr
//   OUT   | ceps/ceps_idx valid; done on the last row
module dct_acc
  import dct_acc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  dct_acc_if.slave    bus
);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_ISSUE = ISSUE;
  localparam logic [2:0] ST_WAIT  = WAIT;
  localparam logic [2:0] ST_ACC   = ACC;
  localparam logic [2:0] ST_OUT   = OUT;

  logic [2:0]               state;
  logic [LOG_AW-1:0]        k;
  logic [IDX_W-1:0]         n;
  logic [COS_AW-1:0]        cos_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [OUT_W-1:0]  ceps_conv;
  logic signed [OUT_W-1:0]  ceps_q;
  logic [IDX_W-1:0]         ceps_idx_q;
  logic                     ceps_valid_q;
  logic                     done_q;
  logic                     k_last;
  logic                     n_last;

  assign k_last  = (k == LOG_AW'(NFILT - 1));
  assign n_last  = (n == IDX_W'(NCEPS - 1));
  assign acc_sum = acc + sext_prod(bus.prod);

  // Convert the post-add sum so ceps is already registered when OUT is entered.
  dct_acc_conv #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_conv (
    .acc  (acc_sum),
    .ceps (ceps_conv)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      k            <= '0;
      n            <= '0;
      cos_q        <= '0;
      acc          <= '0;
      ceps_q       <= '0;
      ceps_idx_q   <= '0;
      ceps_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      ceps_valid_q <= 1'b0;
      done_q       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state <= ST_ISSUE;
            k     <= '0;
            n     <= '0;
            cos_q <= '0;
            acc   <= '0;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT:  state <= ST_ACC;
        ST_ACC: begin
          acc   <= acc_sum;
          cos_q <= cos_q + 1'b1;
          if (k_last) begin
            state        <= ST_OUT;
            ceps_q       <= ceps_conv;
            ceps_idx_q   <= n;
            ceps_valid_q <= 1'b1;
            done_q       <= n_last;
          end else begin
            k     <= k + 1'b1;
            state <= ST_ISSUE;
          end
        end
        ST_OUT: begin
          if (n_last) begin
            state <= ST_IDLE;
          end else begin
            n     <= n + 1'b1;
            k     <= '0;
            acc   <= '0;
            state <= ST_ISSUE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.log_addr   = k;
  assign bus.cos_addr   = cos_q;
  assign bus.mul_en     = (state == ST_ISSUE);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.ceps       = ceps_q;
  assign bus.ceps_idx   = ceps_idx_q;
  assign bus.ceps_valid = ceps_valid_q;
  assign bus.done       = done_q;

endmodule
